// File: rtl/token_rate_scheduler.sv
// token_rate_scheduler: per-channel token rate dividers merged onto one output line by round-robin.
// Ports: clk/rst (async active-low) | a: per-channel input tokens
//        cfg_we/cfg_ch/cfg_div: divide-ratio write (0 disables a channel)
//        b/b_ch: registered output token and its source channel
//        busy: any credit pending | overflow: sticky per-channel credit loss
module token_rate_scheduler #(
    parameter int N_CH = 4,
    parameter int CNT_W = 8,
    parameter int DIV_W = 3,
    parameter int DIV_RST = 2,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  a,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             b,
    output logic [CH_W-1:0]  b_ch,
    output logic             busy,
    output logic [N_CH-1:0]  overflow
);
    logic [DIV_W-1:0] p_q [N_CH];
    logic [DIV_W-1:0] p_d [N_CH];
    logic [DIV_W-1:0] d_q [N_CH];
    logic [DIV_W-1:0] d_d [N_CH];
    logic [CNT_W-1:0] c_q [N_CH];
    logic [CNT_W-1:0] c_d [N_CH];
    logic [N_CH-1:0]  ovf_q, ovf_d, nz;
    logic             b_q;
    logic [CH_W-1:0]  b_ch_q, last_q, gnt_idx;
    logic             gnt_any, hit, wrap, gen, g, full;

    always_comb begin
        for (int i = 0; i < N_CH; i++) nz[i] = |c_q[i];
    end

    // search starts one past the last grant so every pending channel is served in turn
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= N_CH; k++)
            if (!gnt_any && nz[CH_W'((int'(last_q) + k) % N_CH)]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'((int'(last_q) + k) % N_CH);
            end
    end

    // a config write clears the prescaler and discards that cycle's token, but keeps credit
    always_comb begin
        hit   = 1'b0;
        wrap  = 1'b0;
        gen   = 1'b0;
        g     = 1'b0;
        full  = 1'b0;
        ovf_d = ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            hit      = cfg_we && cfg_ch == CH_W'(i);
            wrap     = p_q[i] == d_q[i] - 1'b1;
            gen      = !hit && d_q[i] != '0 && a[i] && wrap;
            g        = gnt_any && gnt_idx == CH_W'(i);
            full     = &c_q[i];
            d_d[i]   = hit ? cfg_div : d_q[i];
            p_d[i]   = (hit || d_q[i] == '0 || (a[i] && wrap)) ? '0 : p_q[i] + DIV_W'(a[i]);
            c_d[i]   = (gen && !g && !full) ? c_q[i] + 1'b1 : (!gen && g) ? c_q[i] - 1'b1 : c_q[i];
            ovf_d[i] = ovf_q[i] | (gen && !g && full);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                p_q[i] <= '0;
                d_q[i] <= DIV_W'(DIV_RST);
                c_q[i] <= '0;
            end
            ovf_q  <= '0;
            b_q    <= 1'b0;
            b_ch_q <= '0;
            last_q <= CH_W'(N_CH - 1);
        end else begin
            p_q   <= p_d;
            d_q   <= d_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            b_q   <= gnt_any;
            if (gnt_any) begin
                b_ch_q <= gnt_idx;
                last_q <= gnt_idx;
            end
        end
    end

    assign b        = b_q;
    assign b_ch     = b_ch_q;
    assign busy     = |nz;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_token_rate_scheduler.sv
// tb_token_rate_scheduler: directed self-checking bench for token_rate_scheduler.
module tb_token_rate_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [2:0] cfg_div = '0;
    logic       b;
    logic [1:0] b_ch;
    logic       busy;
    logic [3:0] overflow;
    int checks = 0;
    int errors = 0;
    int cnt [4];
    int total = 0;

    token_rate_scheduler dut (
        .clk(clk), .rst(rst), .a(a), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .b(b), .b_ch(b_ch), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b === 1'b1) begin
            cnt[b_ch]++;
            total++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        total = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input int dv);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = 3'(dv);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        clr();
        repeat (2) tick();
        chk("rst_b", 32'(b), 0);
        chk("rst_bch", 32'(b_ch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b1;
        tick();

        clr();
        a = 4'h1;
        repeat (7) tick();
        a = 4'h0;
        repeat (20) tick();
        chk("t1_cnt0", 32'(cnt[0]), 3);
        chk("t1_total", 32'(total), 3);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_ovf", 32'(overflow), 0);

        do_reset();
        for (int i = 0; i < 4; i++) cfg(i, 1);
        a = 4'hF;
        tick();
        a = 4'h0;
        chk("t2_b_pre", 32'(b), 0);
        chk("t2_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_b", 32'(b), 1);
            chk("t2_bch", 32'(b_ch), 32'(i));
        end
        tick();
        chk("t2_b_post", 32'(b), 0);

        a = 4'hF;
        repeat (400) tick();
        a = 4'h0;
        tick();
        clr();
        repeat (1100) tick();
        chk("t3_ovf", 32'(overflow), 32'hF);
        for (int i = 0; i < 4; i++) chk("t3_cnt", 32'(cnt[i]), 255);
        chk("t3_total", 32'(total), 1020);
        chk("t3_busy", 32'(busy), 0);

        do_reset();
        for (int i = 0; i < 4; i++) cfg(i, 1);
        clr();
        a = 4'hF;
        repeat (5) tick();
        a = 4'h4;
        cfg(2, 0);
        chk("t4_busy_mid", 32'(busy), 1);
        repeat (49) tick();
        a = 4'h0;
        repeat (40) tick();
        for (int i = 0; i < 4; i++) chk("t4_cnt", 32'(cnt[i]), 5);
        chk("t4_total", 32'(total), 20);
        chk("t4_ovf", 32'(overflow), 0);
        chk("t4_busy", 32'(busy), 0);

        do_reset();
        cfg(1, 3);
        clr();
        a = 4'h2;
        repeat (2) tick();
        cfg(1, 3);
        repeat (2) tick();
        a = 4'h0;
        repeat (10) tick();
        chk("t5_none", 32'(total), 0);
        a = 4'h2;
        tick();
        a = 4'h0;
        repeat (10) tick();
        chk("t5_cnt1", 32'(cnt[1]), 1);
        chk("t5_total", 32'(total), 1);

        do_reset();
        for (int i = 0; i < 4; i++) cfg(i, 1);
        a = 4'hF;
        repeat (4) tick();
        a = 4'h0;
        chk("t6_b_pre", 32'(b), 1);
        chk("t6_busy_pre", 32'(busy), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_b_async", 32'(b), 0);
        chk("t6_busy_async", 32'(busy), 0);
        #2;
        rst = 1'b1;
        clr();
        repeat (20) tick();
        chk("t6_total", 32'(total), 0);
        chk("t6_b", 32'(b), 0);
        chk("t6_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/token_rate_scheduler.md
Name: token_rate_scheduler

Overview:
Rate-divides N_CH independent 1-bit token streams. Each channel has its own programmable divide ratio; halving is the reset default. The block merges the divided tokens onto one shared output token line using round-robin scheduling. It sits between several token producers and a single-token-per-cycle consumer, and generalises the halving token stage into a shared, configurable resource.

Parameters:
N_CH, 4, number of input token channels (2..8)
CNT_W, 8, width of per-channel pending-credit counter
DIV_W, 3, width of per-channel divide-ratio field
DIV_RST, 2, divide ratio loaded into every channel at reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
a  input  N_CH  per-channel input token; 1 = one token this cycle
cfg_we  input  1  config write strobe
cfg_ch  input  $clog2(N_CH)  channel addressed by config write
cfg_div  input  DIV_W  new divide ratio; 0 = channel disabled
b  output  1  output token, registered
b_ch  output  $clog2(N_CH)  source channel of token on b; valid when b=1
busy  output  1  any channel has nonzero pending credit
overflow  output  N_CH  sticky per-channel credit-loss flag

Behaviour:
- Reset (rst=0, asynchronous): b=0, b_ch=0, busy=0, overflow=0, all prescalers=0, all credits=0, all div=DIV_RST, RR pointer set so ch0 has first priority.
- Per-channel prescaler p_i, div d_i:
  - d_i=0: a_i ignored, p_i held at 0. Existing credits still drain.
  - d_i>0: on an edge with a_i=1, if p_i==d_i-1 then p_i<=0 and a credit is generated; otherwise p_i<=p_i+1.
  - d_i=1: every token generates a credit.
- Credit counter c_i (CNT_W bits): +1 on credit generation, -1 when granted.
  - Both on the same edge: c_i unchanged.
  - Generation with c_i at max and no grant: credit lost, c_i stays at max, overflow[i]<=1.
  - Generation at max with a simultaneous grant: not a loss.
  - overflow clears only on reset.
- Arbiter: combinational over registered c_i. Among channels with c_i>0, grant the first found searching from last_grant+1 modulo N_CH. At most one grant per cycle.
  - On a grant: b<=1, b_ch<=idx, last_grant<=idx.
  - Otherwise: b<=0, b_ch holds its previous value.
- Latency: a_i sampled at edge E completes a group -> c_i nonzero after E -> earliest b=1 after edge E+1.
- busy = OR of (c_i!=0), combinational from registers.
- Config: cfg_we=1 at edge E sets d[cfg_ch]<=cfg_div and p[cfg_ch]<=0; a_i at E is discarded for that channel; c[cfg_ch] is kept. Writes to other channels are unaffected.
- Conservation: with no losses, the count of b tokens with b_ch=i equals floor(tokens on a_i since the last reset or config write to i, divided by d_i), summed over config segments.
- Throughput: ≤1 output token per cycle. Sustained aggregate input rate above one credit per cycle accumulates credit and eventually overflows.
- Reset asserted mid-operation: pending credits are discarded. b drops immediately without waiting for clk. No tokens are emitted after release until new input arrives.

Test Plan:
1. Defaults: 7 single-cycle tokens on a[0] only, then idle 20 cycles -> exactly 3 pulses on b, all with b_ch=0; busy=0 at end; overflow=0.
2. Round-robin: all div=1, a=4'hF for one cycle, then 0 -> b high for 4 consecutive cycles with b_ch=0,1,2,3; b=0 afterwards.
3. Saturation: all div=1, a=4'hF held 400 cycles, then 0 -> overflow=4'hF. After a drops, exactly 1020 b tokens (255 per channel, interleaved 0,1,2,3). Channel 0 starts first only if the RR pointer is aligned; the check is per-channel counts.
4. Disable: cfg_div=0 written to ch2, 50 tokens on a[2] -> no b with b_ch=2; overflow[2]=0; credits pending on ch2 before the write still drain.
5. Mid-stream config: ch1 div=3; 2 tokens; rewrite div=3 (prescaler cleared); 2 tokens -> no b; 1 more token -> exactly one b with b_ch=1.
6. Async reset: accumulate ~10 pending credits, pull rst low between clock edges -> b=0 and busy=0 before the next edge. After release with a=0 for 20 cycles, b stays 0.
